// File: rtl/vdp_dma_pkg.sv
// vdp_dma_pkg: register offsets, CTRL strobe bits and FSM states shared by the VDP fill engine.
package vdp_dma_pkg;
    localparam logic [2:0] REG_DST_LO = 3'd0;
    localparam logic [2:0] REG_DST_HI = 3'd1;
    localparam logic [2:0] REG_LEN_LO = 3'd2;
    localparam logic [2:0] REG_LEN_HI = 3'd3;
    localparam logic [2:0] REG_FILL   = 3'd4;
    localparam logic [2:0] REG_STEP   = 3'd5;
    localparam logic [2:0] REG_CTRL   = 3'd6;
    localparam int CTRL_START   = 0;
    localparam int CTRL_ABORT   = 1;
    localparam int CTRL_CLR_IRQ = 2;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
endpackage

// File: rtl/vdp_dma_regs.sv
// vdp_dma_regs: fill-engine register file with a write lock while a transfer runs,
// plus decode of the self-clearing CTRL strobes.
module vdp_dma_regs
    import vdp_dma_pkg::*;
#(
    parameter int ADDR_WIDTH = 14,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  lock_i,
    input  logic                  reg_we_i,
    input  logic [2:0]            reg_addr_i,
    input  logic [7:0]            reg_data_i,
    output logic [ADDR_WIDTH-1:0] dst_o,
    output logic [LEN_WIDTH-1:0]  len_o,
    output logic [7:0]            fill_o,
    output logic [7:0]            step_o,
    output logic                  start_o,
    output logic                  abort_o,
    output logic                  clr_irq_o
);
    logic [7:0]            dst_lo_q, len_lo_q, fill_q, step_q;
    logic [ADDR_WIDTH-9:0] dst_hi_q;
    logic [LEN_WIDTH-9:0]  len_hi_q;
    logic                  wr, ctrl;

    assign wr   = reg_we_i && !lock_i;
    assign ctrl = reg_we_i && reg_addr_i == REG_CTRL;

    always_ff @(posedge clk) begin
        if (reset) begin
            dst_lo_q <= '0;
            dst_hi_q <= '0;
            len_lo_q <= '0;
            len_hi_q <= '0;
            fill_q   <= '0;
            step_q   <= '0;
        end else if (wr) begin
            if (reg_addr_i == REG_DST_LO) dst_lo_q <= reg_data_i;
            if (reg_addr_i == REG_DST_HI) dst_hi_q <= reg_data_i[ADDR_WIDTH-9:0];
            if (reg_addr_i == REG_LEN_LO) len_lo_q <= reg_data_i;
            if (reg_addr_i == REG_LEN_HI) len_hi_q <= reg_data_i[LEN_WIDTH-9:0];
            if (reg_addr_i == REG_FILL)   fill_q   <= reg_data_i;
            if (reg_addr_i == REG_STEP)   step_q   <= reg_data_i;
        end
    end

    assign dst_o     = {dst_hi_q, dst_lo_q};
    assign len_o     = {len_hi_q, len_lo_q};
    assign fill_o    = fill_q;
    assign step_o    = step_q;
    assign start_o   = ctrl && reg_data_i[CTRL_START];
    assign abort_o   = ctrl && reg_data_i[CTRL_ABORT];
    assign clr_irq_o = ctrl && reg_data_i[CTRL_CLR_IRQ];
endmodule

// File: rtl/vdp_dma.sv
// vdp_dma: VDP write-port arbiter (CPU has fixed priority) and strided constant-fill engine.
// Define VDP_DMA_IRQ_EN to expose irq_pending on the irq port.
module vdp_dma
    import vdp_dma_pkg::*;
#(
    parameter int ADDR_WIDTH = 14,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_vdp_we,
    input  logic [ADDR_WIDTH-1:0] cpu_vdp_addr,
    input  logic [7:0]            cpu_vdp_data,
    input  logic                  reg_we,
    input  logic [2:0]            reg_addr,
    input  logic [7:0]            reg_data,
    output logic                  vdp_write_enable,
    output logic [ADDR_WIDTH-1:0] vdp_write_addr,
    output logic [7:0]            vdp_write_data,
    output logic [7:0]            status,
    output logic                  busy
`ifdef VDP_DMA_IRQ_EN
    ,
    output logic                  irq
`endif
);
    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] dst, waddr_q, waddr_d, addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  len, cnt_q, cnt_d;
    logic [7:0]            fill, step, data_q, data_d;
    logic                  start, abort, clr_irq, fill_wr, load;
    logic                  we_q, we_d, irq_q, irq_d;

    vdp_dma_regs #(.ADDR_WIDTH(ADDR_WIDTH), .LEN_WIDTH(LEN_WIDTH)) u_regs (
        .clk       (clk),
        .reset     (reset),
        .lock_i    (state_q != IDLE),
        .reg_we_i  (reg_we),
        .reg_addr_i(reg_addr),
        .reg_data_i(reg_data),
        .dst_o     (dst),
        .len_o     (len),
        .fill_o    (fill),
        .step_o    (step),
        .start_o   (start),
        .abort_o   (abort),
        .clr_irq_o (clr_irq)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = len == '0 ? DONE : RUN;
            RUN:     if (abort || (fill_wr && cnt_q == LEN_WIDTH'(1))) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // A CPU write or an abort in the same cycle holds the engine still.
    always_comb begin
        load    = state_q == IDLE && start;
        fill_wr = state_q == RUN && !abort && !cpu_vdp_we;
        waddr_d = load ? dst : fill_wr ? waddr_q + ADDR_WIDTH'(step) : waddr_q;
        cnt_d   = load ? len : fill_wr ? cnt_q - LEN_WIDTH'(1) : cnt_q;
        we_d    = cpu_vdp_we || fill_wr;
        addr_d  = cpu_vdp_we ? cpu_vdp_addr : waddr_q;
        data_d  = cpu_vdp_we ? cpu_vdp_data : fill;
        irq_d   = state_q == DONE || (irq_q && !clr_irq);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            waddr_q <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            irq_q   <= 1'b0;
        end else begin
            waddr_q <= waddr_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            irq_q   <= irq_d;
        end
    end

    assign vdp_write_enable = we_q;
    assign vdp_write_addr   = addr_q;
    assign vdp_write_data   = data_q;
    assign busy             = state_q == RUN;
    assign status           = {busy, irq_q, 6'b0};
`ifdef VDP_DMA_IRQ_EN
    assign irq = irq_q;
`endif
endmodule

// File: tb/tb_vdp_dma.sv
// tb_vdp_dma: directed checks of arbitration, fill sequencing, abort, reset and irq status.
module tb_vdp_dma;
    logic        clk = 1'b0, reset = 1'b1, cpu_vdp_we = 1'b0, reg_we = 1'b0;
    logic [13:0] cpu_vdp_addr = '0;
    logic [7:0]  cpu_vdp_data = '0, reg_data = '0;
    logic [2:0]  reg_addr = '0;
    logic        vdp_write_enable, busy;
    logic [13:0] vdp_write_addr;
    logic [7:0]  vdp_write_data, status;
`ifdef VDP_DMA_IRQ_EN
    logic        irq;
`endif
    int n_checks = 0, n_fail = 0, cyc = 0, busy_cnt = 0;
    logic [13:0] qa[$];
    logic [7:0]  qd[$];
    int          qc[$];

    vdp_dma dut (
        .clk             (clk),
        .reset           (reset),
        .cpu_vdp_we      (cpu_vdp_we),
        .cpu_vdp_addr    (cpu_vdp_addr),
        .cpu_vdp_data    (cpu_vdp_data),
        .reg_we          (reg_we),
        .reg_addr        (reg_addr),
        .reg_data        (reg_data),
        .vdp_write_enable(vdp_write_enable),
        .vdp_write_addr  (vdp_write_addr),
        .vdp_write_data  (vdp_write_data),
        .status          (status),
        .busy            (busy)
`ifdef VDP_DMA_IRQ_EN
        ,
        .irq             (irq)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (vdp_write_enable) begin
            qa.push_back(vdp_write_addr);
            qd.push_back(vdp_write_data);
            qc.push_back(cyc);
        end
        if (busy) busy_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        reg_we = 1'b1;
        reg_addr = a;
        reg_data = d;
        tick();
        reg_we = 1'b0;
    endtask

    task automatic cfg(input logic [15:0] dst, input logic [15:0] len, input logic [7:0] fill, input logic [7:0] step);
        wr(3'd0, dst[7:0]);
        wr(3'd1, dst[15:8]);
        wr(3'd2, len[7:0]);
        wr(3'd3, len[15:8]);
        wr(3'd4, fill);
        wr(3'd5, step);
    endtask

    task automatic clr();
        qa.delete();
        qd.delete();
        qc.delete();
        busy_cnt = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({vdp_write_enable, vdp_write_addr, vdp_write_data, status, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: we=%b addr=%h data=%h status=%h busy=%b, want all 0", vdp_write_enable, vdp_write_addr, vdp_write_data, status, busy);
        end
`ifdef VDP_DMA_IRQ_EN
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq); end
`endif
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int n0;
        cfg(16'h0100, 16'd4, 8'hAA, 8'd1);
        clr();
        n0 = cyc;
        wr(3'd6, 8'h01);
        n_checks++;
        if (busy !== 1'b1 || vdp_write_enable !== 1'b0) begin n_fail++; $display("FAIL basic_run_entry: busy=%b we=%b want busy=1 we=0", busy, vdp_write_enable); end
        repeat (8) tick();
        n_checks++;
        if (qa.size() != 4) begin n_fail++; $display("FAIL basic_count: got %0d writes want 4", qa.size()); end
        for (int i = 0; i < qa.size() && i < 4; i++) begin
            n_checks++;
            if (qa[i] !== 14'h0100 + 14'(i) || qd[i] !== 8'hAA || qc[i] != n0 + 2 + i) begin
                n_fail++;
                $display("FAIL basic_write%0d: got %h/%h @%0d want %h/aa @%0d", i, qa[i], qd[i], qc[i], 14'h0100 + 14'(i), n0 + 2 + i);
            end
        end
        n_checks++;
        if (busy_cnt != 4) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d want 4", busy_cnt); end
        n_checks++;
        if (status !== 8'h40) begin n_fail++; $display("FAIL basic_status: got %h want 40", status); end
        wr(3'd6, 8'h04);
        n_checks++;
        if (status !== 8'h00) begin n_fail++; $display("FAIL basic_irq_clear: got %h want 00", status); end
    endtask

    task automatic test_contention();
        int n0;
        logic [13:0] ea[5];
        logic [7:0]  ed[5];
        ea = '{14'h0200, 14'h2000, 14'h2000, 14'h0201, 14'h0202};
        ed = '{8'h11, 8'h55, 8'h55, 8'h11, 8'h11};
        cfg(16'h0200, 16'd3, 8'h11, 8'd1);
        clr();
        n0 = cyc;
        wr(3'd6, 8'h01);
        tick();
        cpu_vdp_we = 1'b1;
        cpu_vdp_addr = 14'h2000;
        cpu_vdp_data = 8'h55;
        tick();
        tick();
        cpu_vdp_we = 1'b0;
        repeat (6) tick();
        n_checks++;
        if (qa.size() != 5) begin n_fail++; $display("FAIL contention_count: got %0d writes want 5", qa.size()); end
        for (int i = 0; i < qa.size() && i < 5; i++) begin
            n_checks++;
            if (qa[i] !== ea[i] || qd[i] !== ed[i] || qc[i] != n0 + 2 + i) begin
                n_fail++;
                $display("FAIL contention_write%0d: got %h/%h @%0d want %h/%h @%0d", i, qa[i], qd[i], qc[i], ea[i], ed[i], n0 + 2 + i);
            end
        end
        wr(3'd6, 8'h04);
    endtask

    task automatic test_wrap();
        logic [13:0] ea[3];
        ea = '{14'h3FFE, 14'h0001, 14'h0004};
        cfg(16'hFFFE, 16'd3, 8'h5A, 8'd3);
        clr();
        wr(3'd6, 8'h01);
        repeat (6) tick();
        n_checks++;
        if (qa.size() != 3) begin n_fail++; $display("FAIL wrap_count: got %0d writes want 3", qa.size()); end
        for (int i = 0; i < qa.size() && i < 3; i++) begin
            n_checks++;
            if (qa[i] !== ea[i] || qd[i] !== 8'h5A) begin n_fail++; $display("FAIL wrap_write%0d: got %h/%h want %h/5a", i, qa[i], qd[i], ea[i]); end
        end
        wr(3'd6, 8'h04);
    endtask

    task automatic test_zero_len();
        cfg(16'h0040, 16'd0, 8'h33, 8'd1);
        clr();
        wr(3'd6, 8'h01);
        n_checks++;
        if (busy !== 1'b0 || status !== 8'h00) begin n_fail++; $display("FAIL zero_done_cycle: busy=%b status=%h want 0/00", busy, status); end
        wr(3'd6, 8'h04);
        n_checks++;
        if (status !== 8'h40) begin n_fail++; $display("FAIL zero_set_wins: got %h want 40", status); end
        repeat (3) tick();
        n_checks++;
        if (qa.size() != 0) begin n_fail++; $display("FAIL zero_no_writes: got %0d writes want 0", qa.size()); end
        wr(3'd6, 8'h04);
        cfg(16'h0055, 16'd2, 8'hC3, 8'd0);
        clr();
        wr(3'd6, 8'h01);
        repeat (5) tick();
        n_checks++;
        if (qa.size() != 2) begin n_fail++; $display("FAIL step0_count: got %0d writes want 2", qa.size()); end
        for (int i = 0; i < qa.size() && i < 2; i++) begin
            n_checks++;
            if (qa[i] !== 14'h0055 || qd[i] !== 8'hC3) begin n_fail++; $display("FAIL step0_write%0d: got %h/%h want 0055/c3", i, qa[i], qd[i]); end
        end
        wr(3'd6, 8'h04);
    endtask

    task automatic test_abort();
        cfg(16'h0300, 16'd100, 8'h77, 8'd1);
        clr();
        wr(3'd6, 8'h01);
        wr(3'd0, 8'h99);
        repeat (3) tick();
        wr(3'd6, 8'h02);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
        tick();
        n_checks++;
        if (status !== 8'h40) begin n_fail++; $display("FAIL abort_status: got %h want 40", status); end
        n_checks++;
        if (qa.size() != 4) begin n_fail++; $display("FAIL abort_count: got %0d writes want 4", qa.size()); end
        for (int i = 0; i < qa.size() && i < 4; i++) begin
            n_checks++;
            if (qa[i] !== 14'h0300 + 14'(i)) begin n_fail++; $display("FAIL abort_write%0d: got %h want %h", i, qa[i], 14'h0300 + 14'(i)); end
        end
        wr(3'd6, 8'h04);
        wr(3'd2, 8'd1);
        wr(3'd3, 8'd0);
        clr();
        wr(3'd6, 8'h01);
        repeat (4) tick();
        n_checks++;
        if (qa.size() != 1 || qa[0] !== 14'h0300) begin n_fail++; $display("FAIL abort_dst_locked: got %0d writes first %h want 1 at 0300", qa.size(), qa.size() ? qa[0] : 14'h0); end
        wr(3'd6, 8'h04);
    endtask

    task automatic test_reset_run();
        cfg(16'h0500, 16'd50, 8'hEE, 8'd1);
        wr(3'd6, 8'h01);
        tick();
        tick();
        reset = 1'b1;
        tick();
        n_checks++;
        if ({vdp_write_enable, vdp_write_addr, vdp_write_data, status, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_run_outputs: we=%b addr=%h data=%h status=%h busy=%b, want all 0", vdp_write_enable, vdp_write_addr, vdp_write_data, status, busy);
        end
        reset = 1'b0;
        clr();
        repeat (5) tick();
        n_checks++;
        if (qa.size() != 0 || status !== 8'h00) begin n_fail++; $display("FAIL reset_run_abandon: writes=%0d status=%h want 0/00", qa.size(), status); end
    endtask

`ifdef VDP_DMA_IRQ_EN
    task automatic test_irq();
        cfg(16'h0010, 16'd1, 8'h01, 8'd1);
        wr(3'd6, 8'h01);
        repeat (3) tick();
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_rise: got %b want 1", irq); end
        wr(3'd6, 8'h04);
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear: got %b want 0", irq); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_contention();
        test_wrap();
        test_zero_len();
        test_abort();
        test_reset_run();
`ifdef VDP_DMA_IRQ_EN
        test_irq();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/vdp_dma.md
# vdp_dma

Fill engine and write-port arbiter for the VDP. It sits between the CPU bus and the VDP write port in the CPU clock domain and shares that single port between two sources: direct CPU writes (`vdp_select & cpu_writing`) and a programmable fill engine. The fill engine writes a constant byte across a strided VRAM range. The CPU programs it through a small register window decoded in `top`.

## Interface
Parameters:
- `ADDR_WIDTH`, default 14: VRAM address width; matches the VDP `write_addr`.
- `LEN_WIDTH`, default 16: width of the transfer-length counter.

Ports:
- `clk`  in  1  CPU clock. This is the block's only clock.
- `reset`  in  1  Synchronous, active-high reset.
- `cpu_vdp_we`  in  1  CPU write strobe to the VDP window.
- `cpu_vdp_addr`  in  ADDR_WIDTH  CPU VRAM address.
- `cpu_vdp_data`  in  8  CPU write data.
- `reg_we`  in  1  CPU write strobe to the DMA register window.
- `reg_addr`  in  3  Register offset.
- `reg_data`  in  8  Register write data.
- `vdp_write_enable`  out  1  Registered write enable to the VDP.
- `vdp_write_addr`  out  ADDR_WIDTH  Registered VRAM address.
- `vdp_write_data`  out  8  Registered VRAM data.
- `status`  out  8  Read-back byte: {busy, irq_pending, 6'b0}.
- `busy`  out  1  High while the state is RUN.
- `irq`  out  1  Interrupt request. Present only when `VDP_DMA_IRQ_EN` is defined.

## Operation
Registers, selected by `reg_addr`:
- 0: DST_LO.
- 1: DST_HI. Only bits [ADDR_WIDTH-9:0] are kept.
- 2: LEN_LO.
- 3: LEN_HI.
- 4: FILL.
- 5: STEP, unsigned 0..255.
- 6: CTRL. Bit0 = start, bit1 = abort, bit2 = clear irq.
- 7: reserved. Writes are ignored.

Register rules:
- Registers 0–5 are writable only in IDLE. Writes to them in RUN are dropped.
- The CTRL bits are self-clearing strobes, not stored state.

States:
- IDLE:
  - CTRL start with LEN≠0 loads the working address and count from DST and LEN, then moves to RUN.
  - CTRL start with LEN=0 moves straight to DONE. No VRAM write is issued.
  - Abort in IDLE has no effect.
- RUN: each cycle the block either grants the port to the CPU or issues one fill write.
  - On a fill write: addr ← (addr + STEP) mod 2^ADDR_WIDTH, count ← count − 1.
  - Moves to DONE after the write where count reaches 0.
  - Abort moves to DONE in the next cycle. No further fill writes are issued.
  - Start while in RUN is ignored.
- DONE: lasts one cycle. Sets `irq_pending`, then returns to IDLE.

Arbitration:
- The CPU has fixed priority. If `cpu_vdp_we` is high, that cycle's port slot carries the CPU write and the fill engine stalls: no address or count change.
- The CPU is never stalled or dropped.

Arithmetic:
- Address addition wraps silently at 2^ADDR_WIDTH.
- STEP=0 is legal: it writes the same address LEN times.
- The DST and LEN registers are not modified by a transfer. Repeating start repeats the same fill.

`irq_pending`:
- Set on entry to DONE.
- Cleared by CTRL bit2.
- Set wins if set and clear happen in the same cycle.

Simultaneous CTRL bits:
- abort+start in IDLE: start wins.
- abort+start in RUN: abort wins.

Reset clears:
- all registers;
- `irq_pending`;
- the state, to IDLE;
- all outputs to 0.

Reset during RUN abandons the transfer. No DONE is entered and no irq is raised.

## Timing
- All outputs are registered.
- A CPU write presented in cycle N appears on `vdp_write_*` in cycle N+1.
- A CTRL start in cycle N puts the block in RUN in cycle N+1. The first fill write appears on the port in cycle N+2, given no CPU contention.
- Throughput is one fill write per uncontended cycle. A LEN of L with no contention takes L cycles in RUN, plus one DONE cycle.
- `busy` rises in cycle N+1. It falls in the cycle the state enters DONE.
- `irq_pending` (and `status[6]`) are visible in the cycle after DONE.
- `vdp_write_enable` is a single-cycle pulse per write. Its address and data are valid in the same cycle.

## Configuration
`VDP_DMA_IRQ_EN`:
- Defined: `irq` exists and equals `irq_pending`. CTRL bit2 clears it.
- Undefined: `irq` is not present. `irq_pending` still exists and is visible only through `status[6]`, so software polls.

## Structure
- Package `vdp_dma_pkg` holds:
  - the register offset constants (REG_DST_LO…REG_CTRL);
  - the CTRL bit indices;
  - the state enum {IDLE, RUN, DONE}.
- Sub-module `vdp_dma_regs` holds:
  - the register file;
  - the RUN-time write lock;
  - CTRL strobe decode.
- The FSM, counters and port mux stay in `vdp_dma`.

## Test plan
- **Basic fill:** DST=0x0100, LEN=4, FILL=0xAA, STEP=1, start → writes of 0xAA to 0x0100–0x0103 on 4 consecutive cycles; `busy` high for 4 cycles; `status` = 0x40 afterwards.
- **CPU contention:** during a LEN=3 fill, assert `cpu_vdp_we` (0x2000, 0x55) for 2 cycles mid-transfer → CPU writes appear in order at N+1; the fill completes 3 writes with no gaps or duplicates; the total takes 5 port cycles.
- **Wrap and stride:** DST=0x3FFE, STEP=3, LEN=3 → writes to 0x3FFE, 0x0001, 0x0004.
- **Zero length and step zero:**
  - LEN=0 start → no writes; `irq_pending` set after 1 cycle.
  - STEP=0, LEN=2 → two writes to the same address.
- **Abort:** with LEN=100, abort 5 cycles after start → at most 5 fill writes; DONE follows; writes to DST during RUN leave DST unchanged.
- **Reset mid-RUN:** reset asserted in RUN → the next cycle shows IDLE, all outputs 0 and `irq_pending`=0. With `VDP_DMA_IRQ_EN`, also check that `irq` rises after a completed fill and falls on CTRL=0x04.
